// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: oversamples SCL/SDA on clk and turns each received data
// byte into a one-cycle register-write strobe with an auto-incrementing pointer.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_cond, stop_cond;

  logic [7:0] shreg, shreg_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic       byte_done, byte_done_n;
  logic       sda_oe_n, wr_en_n, busy_n;
  logic [7:0] wr_addr_n, wr_data_n;
  logic [7:0] full_byte;

  // Synchronizers reset to the idle-bus level so reset release creates no edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_cond = scl_s & scl_d & ~sda_s & sda_d;
  assign stop_cond  = scl_s & scl_d & sda_s & ~sda_d;
  assign full_byte  = {shreg[6:0], sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= 8'h00;
      bitcnt    <= 3'd0;
      byte_done <= 1'b0;
      sda_oe    <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bitcnt    <= bitcnt_n;
      byte_done <= byte_done_n;
      sda_oe    <= sda_oe_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      busy      <= busy_n;
    end
  end

  // byte_done marks "8 bits in, waiting for the SCL fall that opens the ACK slot".
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bitcnt_n    = bitcnt;
    byte_done_n = byte_done;
    sda_oe_n    = sda_oe;
    wr_en_n     = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    busy_n      = busy;

    if (stop_cond) begin
      state_n     = IDLE;
      bitcnt_n    = 3'd0;
      byte_done_n = 1'b0;
      sda_oe_n    = 1'b0;
      busy_n      = 1'b0;
    end else if (start_cond) begin
      state_n     = ADDR;
      bitcnt_n    = 3'd0;
      byte_done_n = 1'b0;
      sda_oe_n    = 1'b0;
      busy_n      = 1'b1;
    end else begin
      case (state)
        ADDR, REG, DATA: begin
          if (scl_rise && !byte_done) begin
            shreg_n  = full_byte;
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              byte_done_n = 1'b1;
              if (state == ADDR) begin
                if (full_byte[7:1] != SLAVE_ADDR || full_byte[0]) begin
                  byte_done_n = 1'b0;
                  state_n     = IGNORE;
                end
              end else if (state == REG) begin
                wr_addr_n = full_byte;
              end else begin
                wr_data_n = full_byte;
                wr_en_n   = 1'b1;
              end
            end
          end else if (scl_fall && byte_done) begin
            byte_done_n = 1'b0;
            sda_oe_n    = 1'b1;
            case (state)
              ADDR:    state_n = ADDR_ACK;
              REG:     state_n = REG_ACK;
              default: state_n = DATA_ACK;
            endcase
          end
        end
        ADDR_ACK, REG_ACK, DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            bitcnt_n = 3'd0;
            case (state)
              ADDR_ACK: state_n = REG;
              REG_ACK:  state_n = DATA;
              default: begin
                state_n   = DATA;
                wr_addr_n = wr_addr + 8'd1;
              end
            endcase
          end
        end
        IGNORE:  sda_oe_n = 1'b0;
        default: ;
      endcase
    end
  end

endmodule
